// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial
//   Serial binary -> packed BCD converter (double-dabble). It handles one
//   input bit per clock, so a WIDTH-bit word takes WIDTH shift cycles.
//   Both sides use a valid/ready handshake. The converter accepts a word
//   only in IDLE. It holds a result in DONE until the result is taken.
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   in_valid_i     in_data_i is valid
//   in_ready_o     converter is idle and can take a word
//   in_data_i      unsigned binary operand (WIDTH bits)
//   out_valid_o    out_bcd_o / out_ndigits_o hold a finished result
//   out_ready_i    downstream takes the result
//   out_bcd_o      packed BCD, digit k at [4k+3:4k], digit 0 = units
//   out_ndigits_o  number of significant digits, 1..DIGITS
module bin2bcd_serial #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int CW     = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*DIGITS-1:0]   out_bcd_o,
    output logic [3:0]            out_ndigits_o
);

    // Elaboration-time parameter checks
    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    if (WIDTH < 1 || WIDTH > 63) begin : g_err_width
        $error("bin2bcd_serial: WIDTH must be in 1..63");
    end
    if (DIGITS < 1 || DIGITS > 15) begin : g_err_digits
        $error("bin2bcd_serial: DIGITS must be in 1..15");
    end else if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_err_range
        $error("bin2bcd_serial: 10**DIGITS must exceed 2**WIDTH-1");
    end
    if ((64'd1 << CW) <= 64'(WIDTH)) begin : g_err_cw
        $error("bin2bcd_serial: 2**CW must exceed WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [4*DIGITS-1:0]   out_bcd_q, out_bcd_d;
    logic [3:0]            out_nd_q, out_nd_d;

    logic [4*DIGITS-1:0]       bcd_corr;
    logic [4*DIGITS+WIDTH-1:0] cat_sh;
    logic [4*DIGITS-1:0]       bcd_next;
    logic [3:0]                nd_next;

    // Add-3 correction on every digit that is >= 5. Afterwards the shift
    // doubles it, and the result stays a legal digit plus a carry into the
    // next digit.
    always_comb begin
        bcd_corr = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_corr[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    assign cat_sh   = {bcd_corr, bin_q} << 1;
    assign bcd_next = cat_sh[WIDTH +: 4*DIGITS];

    // Significant digits = index of the highest nonzero digit + 1 (min 1).
    always_comb begin
        nd_next = 4'd1;
        for (int k = 1; k < DIGITS; k++) begin
            if (bcd_next[4*k +: 4] != 4'd0) nd_next = 4'(k + 1);
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_nd_d    = out_nd_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    bin_d   = in_data_i;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = cat_sh[WIDTH-1:0];
                bcd_d = bcd_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_bcd_d   = bcd_next;
                    out_nd_d    = nd_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_nd_q    <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_nd_q    <= out_nd_d;
        end
    end

    assign in_ready_o    = (state_q == IDLE);
    assign out_valid_o   = out_valid_q;
    assign out_bcd_o     = out_bcd_q;
    assign out_ndigits_o = out_nd_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
module tb_bin2bcd_serial;
    localparam int W = 16;
    localparam int D = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [4*D-1:0]  out_bcd;
    logic [3:0]      out_ndigits;

    int n_vec  = 0;
    int n_fail = 0;

    bin2bcd_serial #(.WIDTH(W), .DIGITS(D), .CW(5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_bcd_o(out_bcd), .out_ndigits_o(out_ndigits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference built from division, independent of any shift algorithm.
    function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
        logic [4*D-1:0] r = '0;
        int unsigned p = 1;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] n_digits(input int unsigned v);
        int n = 1;
        int unsigned t = v / 10;
        while (t != 0) begin n++; t = t / 10; end
        return 4'(n);
    endfunction

    // Transaction-level model: idle / busy for W edges / holding a result.
    int             m_phase = 0;    // 0 idle, 1 converting, 2 result held
    int             m_left  = 0;
    int unsigned    m_val   = 0;
    logic [4*D-1:0] m_bcd   = '0;
    logic [3:0]     m_nd    = '0;
    int             m_accepts = 0;
    int             m_results = 0;

    // Compare on the falling edge; then advance the model using the inputs
    // the next rising edge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_bcd = '0; m_nd = '0;
        end
        chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
        chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
        chk("out_bcd", 32'(out_bcd), 32'(m_bcd));
        chk("out_ndigits", 32'(out_ndigits), 32'(m_nd));
        if (in_ready && out_valid) chk("ready_valid_excl", 32'(1), 32'(0));
        if (rst_n) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_val = in_data; m_left = W; m_phase = 1; m_accepts++;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_bcd = to_bcd(m_val); m_nd = n_digits(m_val);
                        m_phase = 2; m_results++;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        int i = 0;
        while (!in_ready && i < 100) begin tick(); i++; end
        if (!in_ready) chk("in_ready_timeout", 32'(0), 32'(1));
    endtask

    // Offer v, check latency and the literal result, then leave it held
    // (out_ready low) for the caller.
    task automatic convert_hold(input logic [W-1:0] v, input logic [4*D-1:0] eb,
                                input logic [3:0] en, input string name);
        int lat = 0;
        wait_ready();
        in_valid = 1'b1; in_data = v;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        chk({name, "_latency"}, 32'(lat), 32'(W));
        chk({name, "_bcd"}, 32'(out_bcd), 32'(eb));
        chk({name, "_nd"}, 32'(out_ndigits), 32'(en));
    endtask

    task automatic release_out();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    int acc0;
    int cyc;

    initial begin
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_bcd", 32'(out_bcd), 32'(0));
        chk("reset_nd", 32'(out_ndigits), 32'(0));
        @(posedge clk); #1; rst_n = 1'b1;
        tick();

        // Directed conversions, including the digit-count boundaries.
        convert_hold(16'd0,     20'h00000, 4'd1, "zero");  release_out();
        convert_hold(16'd65535, 20'h65535, 4'd5, "max");   release_out();
        convert_hold(16'd9999,  20'h09999, 4'd4, "9999");  release_out();
        convert_hold(16'd10000, 20'h10000, 4'd5, "10000"); release_out();
        convert_hold(16'd9,     20'h00009, 4'd1, "9");     release_out();
        convert_hold(16'd10,    20'h00010, 4'd2, "10");    release_out();

        // Backpressure: the result stays put and no new word is accepted.
        convert_hold(16'd4321, 20'h04321, 4'd4, "bp");
        in_valid = 1'b1; in_data = 16'd7;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            chk("bp_bcd", 32'(out_bcd), 32'(20'h04321));
        end
        in_valid = 1'b0;
        release_out();
        chk("bp_release_in_ready", 32'(in_ready), 32'(1));

        // Reset during the 8th shift cycle discards the conversion.
        wait_ready();
        in_valid = 1'b1; in_data = 16'd1234;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("rst_no_valid", 32'(out_valid), 32'(0));
        end
        convert_hold(16'd42, 20'h00042, 4'd2, "after_rst"); release_out();

        // Operand changes after acceptance are ignored.
        wait_ready();
        acc0 = m_accepts;
        in_valid = 1'b1; in_data = 16'd500;
        tick();
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            in_data = W'($urandom); tick(); cyc++;
        end
        in_valid = 1'b0;
        chk("hold_bcd", 32'(out_bcd), 32'(20'h00500));
        chk("hold_accepts", 32'(m_accepts - acc0), 32'(1));
        release_out();

        // Random back-to-back traffic against the model.
        acc0 = m_results;
        cyc = 0;
        while (m_results - acc0 < 2000 && cyc < 90000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: in_data = '0;
                1: in_data = '1;
                2: in_data = W'($urandom_range(9990, 10010));
                default: in_data = W'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("random_count", 32'(m_results - acc0 >= 2000), 32'(1));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
